// File: rtl/fir_error_monitor.sv
// Per-frame error scoring of the FIR output stream against a golden stream.
// Accumulates saturating sum |err|, worst-case |err| and mismatch count.
module fir_error_monitor #(
    parameter int W         = 16,
    parameter int FRAME_LEN = 32,
    parameter int SKIP      = 3,
    parameter int SUM_W     = 22,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [W-1:0]     dut_sample,
    input  logic [W-1:0]     ref_sample,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [W:0]       max_abs_err,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN,
        REPORT
    } state_t;

    localparam int ACC_W = ((SUM_W > W + 1) ? SUM_W : W + 1) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;
    localparam logic [CNT_W-1:0] SKIP_LAST =
        CNT_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] skip_cnt;
    logic [CNT_W-1:0] sample_cnt;

    logic signed [W:0] diff;
    logic [W:0]        abs_err;
    logic [ACC_W-1:0]  sum_wide;
    logic              sat_hit;
    logic              clear;
    logic              score;

    always_comb begin
        diff = $signed({dut_sample[W-1], dut_sample})
             - $signed({ref_sample[W-1], ref_sample});
        abs_err = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        sum_wide = ACC_W'(sum_abs_err) + ACC_W'(abs_err);
        sat_hit = sum_wide > ACC_W'(SUM_MAX);
        clear = (state == IDLE) && start;
        score = (state == RUN) && in_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (SKIP > 0) ? WARMUP : RUN;
            end
            WARMUP: begin
                if (in_valid && skip_cnt == SKIP_LAST) state_nx = RUN;
            end
            RUN: begin
                if (in_valid && sample_cnt == FRAME_LAST) state_nx = REPORT;
            end
            REPORT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Flags follow the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            mismatch_cnt <= '0;
            sat          <= 1'b0;
            skip_cnt     <= '0;
            sample_cnt   <= '0;
        end else begin
            busy <= (state_nx == WARMUP) || (state_nx == RUN);
            done <= (state_nx == REPORT);
            if (clear) begin
                sum_abs_err  <= '0;
                max_abs_err  <= '0;
                mismatch_cnt <= '0;
                sat          <= 1'b0;
                skip_cnt     <= '0;
                sample_cnt   <= '0;
            end else if (state == WARMUP && in_valid) begin
                skip_cnt <= skip_cnt + 1'b1;
            end else if (score) begin
                if (sat_hit) begin
                    sum_abs_err <= SUM_MAX;
                    sat         <= 1'b1;
                end else begin
                    sum_abs_err <= sum_wide[SUM_W-1:0];
                end
                if (abs_err > max_abs_err) max_abs_err <= abs_err;
                if (abs_err != '0) mismatch_cnt <= mismatch_cnt + 1'b1;
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_error_monitor.sv
// Directed bench for fir_error_monitor: default build plus a narrow
// SUM_W=16 build sharing the same stimulus to exercise saturation.
module tb_fir_error_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [15:0] dut_sample;
    logic [15:0] ref_sample;

    logic        a_busy, a_done, a_sat;
    logic [21:0] a_sum;
    logic [16:0] a_max;
    logic [5:0]  a_mism;

    logic        b_busy, b_done, b_sat;
    logic [15:0] b_sum;
    logic [16:0] b_max;
    logic [5:0]  b_mism;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] dv[35];
    logic [15:0] rv[35];

    always #5 clk = ~clk;

    fir_error_monitor u_main (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .dut_sample(dut_sample), .ref_sample(ref_sample),
        .busy(a_busy), .done(a_done), .sum_abs_err(a_sum),
        .max_abs_err(a_max), .mismatch_cnt(a_mism), .sat(a_sat)
    );

    fir_error_monitor #(.SUM_W(16)) u_narrow (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .dut_sample(dut_sample), .ref_sample(ref_sample),
        .busy(b_busy), .done(b_done), .sum_abs_err(b_sum),
        .max_abs_err(b_max), .mismatch_cnt(b_mism), .sat(b_sat)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s,
                         input logic [15:0] d, input logic [15:0] r);
        @(negedge clk);
        in_valid   = v;
        start      = s;
        dut_sample = d;
        ref_sample = r;
    endtask

    task automatic begin_frame(input bit noise);
        if (noise)
            repeat (3) drive(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        drive(noise, 1'b1, 16'h1234, 16'h0000);
    endtask

    task automatic feed(input int n, input bit gaps, input bit noise);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 2))
                    drive(1'b0, noise && i > 5, 16'($urandom), 16'($urandom));
            drive(1'b1, 1'b0, dv[i], rv[i]);
        end
    endtask

    task automatic play(input string tag, input int e_sum, input int e_max,
                        input int e_mism, input int e_sat,
                        input bit gaps, input bit noise);
        int ndone;
        int first;
        ndone = 0;
        first = -1;
        begin_frame(noise);
        feed(35, gaps, noise);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, noise && k == 0, 16'($urandom), 16'($urandom));
            if (a_done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        check({tag, "_done_cnt"}, 32'(ndone), 32'd1);
        check({tag, "_latency"}, 32'(first), 32'd0);
        check({tag, "_sum"}, 32'(a_sum), 32'(e_sum));
        check({tag, "_max"}, 32'(a_max), 32'(e_max));
        check({tag, "_mism"}, 32'(a_mism), 32'(e_mism));
        check({tag, "_sat"}, 32'(a_sat), 32'(e_sat));
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
    endtask

    task automatic fill_offset;
        for (int i = 0; i < 35; i++) begin
            rv[i] = 16'(i * 100 - 1000);
            dv[i] = (i < 3) ? rv[i] + 16'd500 : rv[i] + 16'd1;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        dut_sample = '0;
        ref_sample = '0;
        #12;
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_sum", 32'(a_sum), 32'd0);
        check("rst_max", 32'(a_max), 32'd0);
        check("rst_mism", 32'(a_mism), 32'd0);
        check("rst_sat", 32'(a_sat), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 35; i++) begin
            rv[i] = 16'(i * 37 - 500);
            dv[i] = rv[i];
        end
        play("t2", 0, 0, 0, 0, 1'b0, 1'b0);

        fill_offset();
        play("t3", 32, 1, 32, 0, 1'b0, 1'b0);

        for (int i = 0; i < 35; i++) begin
            rv[i] = 16'(i * 11);
            dv[i] = rv[i];
        end
        dv[8] = 16'h7FFF;
        rv[8] = 16'h8000;
        play("t4", 65535, 65535, 1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 35; i++) begin
            rv[i] = 16'd100;
            dv[i] = (i % 2 == 1) ? 16'd4100 : 16'(-3900);
        end
        play("t5", 128000, 4000, 32, 0, 1'b0, 1'b0);
        check("t5n_sum", 32'(b_sum), 32'd65535);
        check("t5n_sat", 32'(b_sat), 32'd1);
        check("t5n_max", 32'(b_max), 32'd4000);
        check("t5n_mism", 32'(b_mism), 32'd32);

        fill_offset();
        play("t6", 32, 1, 32, 0, 1'b1, 1'b1);
        check("t6n_sat", 32'(b_sat), 32'd0);
        check("t6n_sum", 32'(b_sum), 32'd32);

        fill_offset();
        begin_frame(1'b0);
        feed(10, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        check("t1_busy_pre", 32'(a_busy), 32'd1);
        check("t1_mism_pre", 32'(a_mism), 32'd7);
        check("t1_sum_pre", 32'(a_sum), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_busy", 32'(a_busy), 32'd0);
        check("t1_done", 32'(a_done), 32'd0);
        check("t1_sum", 32'(a_sum), 32'd0);
        check("t1_max", 32'(a_max), 32'd0);
        check("t1_mism", 32'(a_mism), 32'd0);
        check("t1_sat", 32'(a_sat), 32'd0);
        check("t1n_sum", 32'(b_sum), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_idle_busy", 32'(a_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
